// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: control inputs, imem port and IF/ID outputs.
// master = fetch unit, slave = pipeline/memory side.
interface instruction_fetch_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     stall_i;
  logic                     flush_i;
  logic                     redirect_i;
  logic [ADDRESS_WIDTH-1:0] redirect_pc_i;
  logic [ADDRESS_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0]    imem_instr_i;
  logic [ADDRESS_WIDTH-1:0] if_pc_o;
  logic [ADDRESS_WIDTH-1:0] if_pc4_o;
  logic [DATA_WIDTH-1:0]    if_instr_o;
  logic                     if_valid_o;
  logic                     fault_o;

  modport master (
    input  stall_i, flush_i, redirect_i,
    input  redirect_pc_i, imem_instr_i,
    output imem_addr_o, if_pc_o, if_pc4_o,
    output if_instr_o, if_valid_o, fault_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i,
    output redirect_pc_i, imem_instr_i,
    input  imem_addr_o, if_pc_o, if_pc4_o,
    input  if_instr_o, if_valid_o, fault_o
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, IF/ID register, stall/flush/redirect, sticky fault.
// Define FETCH_BOUNDS_CHECK_EN to fault on fetches beyond MEM_SIZE words.
module instruction_fetch #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_SIZE      = 256,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR =
    DATA_WIDTH'(32'h0000_0013)
) (
  input logic clk,
  input logic rst,
  instruction_fetch_if.master bus
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP =
    ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-3:0] MEM_WORDS =
    (ADDRESS_WIDTH-2)'(MEM_SIZE);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [ADDRESS_WIDTH-1:0] if_pc4_q, if_pc4_d;
  logic [DATA_WIDTH-1:0]    if_instr_q, if_instr_d;
  logic                     if_valid_q, if_valid_d;
  logic                     fault_q, fault_d;
  logic                     out_of_range;
  logic                     misaligned;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign out_of_range =
    (pc_q[ADDRESS_WIDTH-1:2] >= MEM_WORDS);
`else
  logic unused_mem_words;
  assign unused_mem_words = ^MEM_WORDS;
  assign out_of_range = 1'b0;
`endif

  assign misaligned = (bus.redirect_pc_i[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    fault_d    = fault_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // redirect beats flush, flush beats stall
        if (bus.redirect_i) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          if (misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = bus.redirect_pc_i;
          end
        end else if (bus.flush_i) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else if (!bus.stall_i) begin
          if (out_of_range) begin
            state_d    = FAULT;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            fault_d    = 1'b1;
          end else begin
            if_instr_d = bus.imem_instr_i;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_q + PC_STEP;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_STEP;
          end
        end
      end
      FAULT: begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
        fault_d    = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_pc4_q   <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.imem_addr_o = pc_q;
  assign bus.if_pc_o     = if_pc_q;
  assign bus.if_pc4_o    = if_pc4_q;
  assign bus.if_instr_o  = if_instr_q;
  assign bus.if_valid_o  = if_valid_q;
  assign bus.fault_o     = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle model compare plus directed checks.
// Second instance exercises RESET_PC wrap at the top of the address space.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) ifc0();
  instruction_fetch_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) ifc1();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign ifc0.imem_instr_i = mem_word(ifc0.imem_addr_o);
  assign ifc1.imem_instr_i = mem_word(ifc1.imem_addr_o);
  assign ifc1.stall_i       = 1'b0;
  assign ifc1.flush_i       = 1'b0;
  assign ifc1.redirect_i    = 1'b0;
  assign ifc1.redirect_pc_i = 32'h0;

  instruction_fetch dut0 (
    .clk (clk),
    .rst (rst),
    .bus (ifc0.master)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (ifc1.master)
  );

  // Behavioural model of dut0 (mode: 0 boot, 1 run, 2 fault)
  int          m_mode;
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_fault;

  always @(posedge clk) begin
    if (rst) begin
      m_known = 1'b1;
      m_mode  = 0;
      m_pc    = 32'h0;
      m_ipc   = 32'h0;
      m_ipc4  = 32'h0;
      m_instr = NOP;
      m_valid = 1'b0;
      m_fault = 1'b0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (ifc0.redirect_i && ifc0.redirect_pc_i % 4 != 0) begin
        m_mode  = 2;
        m_fault = 1'b1;
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (ifc0.redirect_i) begin
        m_pc    = ifc0.redirect_pc_i;
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (ifc0.flush_i) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end else if (!ifc0.stall_i) begin
`ifdef FETCH_BOUNDS_CHECK_EN
        if (m_pc / 4 >= 256) begin
          m_mode  = 2;
          m_fault = 1'b1;
          m_valid = 1'b0;
          m_instr = NOP;
        end else begin
`else
        begin
`endif
          m_instr = mem_word(m_pc);
          m_ipc   = m_pc;
          m_ipc4  = m_pc + 32'd4;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      checks++;
      if (ifc0.imem_addr_o !== m_pc || ifc0.if_pc_o !== m_ipc ||
          ifc0.if_pc4_o !== m_ipc4 || ifc0.if_instr_o !== m_instr ||
          ifc0.if_valid_o !== m_valid || ifc0.fault_o !== m_fault) begin
        errs++;
        $display("FAIL model t=%0t got addr=%h pc=%h pc4=%h ins=%h v=%b f=%b want addr=%h pc=%h pc4=%h ins=%h v=%b f=%b",
          $time, ifc0.imem_addr_o, ifc0.if_pc_o, ifc0.if_pc4_o,
          ifc0.if_instr_o, ifc0.if_valid_o, ifc0.fault_o,
          m_pc, m_ipc, m_ipc4, m_instr, m_valid, m_fault);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic fl,
                      input logic rd, input logic [31:0] rpc);
    ifc0.stall_i       = st;
    ifc0.flush_i       = fl;
    ifc0.redirect_i    = rd;
    ifc0.redirect_pc_i = rpc;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", 32'(ifc0.if_valid_o), 32'd0);
    chk("rst_instr", ifc0.if_instr_o, NOP);
    chk("rst_pc", ifc0.if_pc_o, 32'h0);
    chk("rst_pc4", ifc0.if_pc4_o, 32'h0);
    chk("rst_addr", ifc0.imem_addr_o, 32'h0);
    chk("rst_fault", 32'(ifc0.fault_o), 32'd0);
    chk("rst_addr1", ifc1.imem_addr_o, 32'hFFFF_FFFC);

    rst = 1'b0;
    // boot cycle must ignore a misaligned redirect
    step(1'b0, 1'b1, 1'b1, 32'h2);
    chk("boot_addr", ifc0.imem_addr_o, 32'h0);
    chk("boot_fault", 32'(ifc0.fault_o), 32'd0);
    chk("boot_valid", 32'(ifc0.if_valid_o), 32'd0);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("f0_valid", 32'(ifc0.if_valid_o), 32'd1);
    chk("f0_pc", ifc0.if_pc_o, 32'h0);
    chk("f0_instr", ifc0.if_instr_o, 32'h1000_0000);
    chk("f0_pc4", ifc0.if_pc4_o, 32'h4);
    chk("w_pc", ifc1.if_pc_o, 32'hFFFF_FFFC);
    chk("w_pc4", ifc1.if_pc4_o, 32'h0);
    chk("w_addr", ifc1.imem_addr_o, 32'h0);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("f1_pc", ifc0.if_pc_o, 32'h4);
    chk("f1_instr", ifc0.if_instr_o, 32'h1000_0001);
    chk("f1_pc4", ifc0.if_pc4_o, 32'h8);
    chk("w2_pc", ifc1.if_pc_o, 32'h0);
    chk("w2_valid", 32'(ifc1.if_valid_o), 32'd1);
    chk("w2_fault", 32'(ifc1.fault_o), 32'd0);

    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_pc", ifc0.if_pc_o, 32'h4);
      chk("stall_addr", ifc0.imem_addr_o, 32'h8);
    end

    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("f2_pc", ifc0.if_pc_o, 32'h8);
    chk("f2_instr", ifc0.if_instr_o, 32'h1000_0002);
    chk("f2_pc4", ifc0.if_pc4_o, 32'hC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("f3_addr", ifc0.imem_addr_o, 32'h10);

    step(1'b1, 1'b0, 1'b1, 32'h28);
    chk("rd_valid", 32'(ifc0.if_valid_o), 32'd0);
    chk("rd_instr", ifc0.if_instr_o, NOP);
    chk("rd_addr", ifc0.imem_addr_o, 32'h28);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_pc", ifc0.if_pc_o, 32'h28);
    chk("rd_tinstr", ifc0.if_instr_o, 32'h1000_000A);

    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fl_valid", 32'(ifc0.if_valid_o), 32'd0);
    chk("fl_addr", ifc0.imem_addr_o, 32'h2C);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fl_next", ifc0.if_pc_o, 32'h2C);

    step(1'b0, 1'b0, 1'b1, 32'h3FC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("top_instr", ifc0.if_instr_o, 32'h1000_00FF);
    chk("top_valid", 32'(ifc0.if_valid_o), 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("oob_fault", 32'(ifc0.fault_o), 32'd1);
    chk("oob_valid", 32'(ifc0.if_valid_o), 32'd0);
    chk("oob_addr", ifc0.imem_addr_o, 32'h400);
`else
    chk("oob_valid", 32'(ifc0.if_valid_o), 32'd1);
    chk("oob_pc", ifc0.if_pc_o, 32'h400);
    chk("oob_instr", ifc0.if_instr_o, 32'h1000_0100);
`endif

    step(1'b0, 1'b0, 1'b1, 32'h2);
    chk("mis_fault", 32'(ifc0.fault_o), 32'd1);
    chk("mis_valid", 32'(ifc0.if_valid_o), 32'd0);
    chk("mis_instr", ifc0.if_instr_o, NOP);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("frz_addr", ifc0.imem_addr_o, 32'h400);
`else
    chk("frz_addr", ifc0.imem_addr_o, 32'h404);
`endif
    chk("frz_fault", 32'(ifc0.fault_o), 32'd1);

    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 32'h28);
    chk("rr_addr", ifc0.imem_addr_o, 32'h0);
    chk("rr_fault", 32'(ifc0.fault_o), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rr_valid", 32'(ifc0.if_valid_o), 32'd1);
    chk("rr_instr", ifc0.if_instr_o, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
